fixed_to_float_packer: RTL

FIXED_TO_FLOAT_PACKER -- requirements
Module: fixed_to_float_packer

---
 rtl/cordic_pkg.sv | 22 ++
 rtl/lzc32.sv | 25 ++
 rtl/fixed_to_float_packer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC number-format blocks.
//
// Contents:
//   FP_BIAS, FP_EXP_W, FP_MAN_W : IEEE-754 single-precision field parameters
//   FRAC_BITS_DEFAULT           : default fractional bits of the Q2.30 CORDIC format
//   float32_t                   : packed single-precision layout {sign, exp, man}
package cordic_pkg;

  localparam int FP_BIAS  = 127;
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;

  // CORDIC x/y/theta values are Q2.30.
  localparam int FRAC_BITS_DEFAULT = 30;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W-1:0] man;
  } float32_t;

endpackage

// File: rtl/lzc32.sv
// 32-bit leading-zero counter (combinational priority encoder).
//
// Ports:
//   value : input  [31:0] word to scan
//   count : output [5:0]  number of leading zeros, 0..31, or 32 when value is 0
//   zero  : output        value is all zeros
module lzc32 (
  input  logic [31:0] value,
  output logic [5:0]  count,
  output logic        zero
);

  // Scan upward so the highest set bit is the last one written.
  always_comb begin
    count = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (value[i]) begin
        count = 6'(31 - i);
      end
    end
  end

  assign zero = (value == 32'd0);

endmodule

// File: rtl/fixed_to_float_packer.sv
// Converts a signed fixed-point value (FRAC_BITS fractional bits) into an
// IEEE-754 single-precision float, round-to-nearest-even.
//
// Pipeline:
//   S1 sign / magnitude
//   S2 leading-zero count and normalise
//   S3 exponent, round, pack (S3 is the output register)
//
// Ports:
//   clk       : input        rising-edge clock
//   rst_n     : input        asynchronous active-low reset
//   in_valid  : input        in_data is valid
//   in_ready  : output       block accepts in_data this cycle
//   in_data   : input  [31:0] two's-complement fixed-point value
//   out_valid : output       out_data holds a converted result
//   out_ready : input        consumer accepts out_data this cycle
//   out_data  : output [31:0] single-precision result
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high at that port. The whole pipe moves together on advance =
// !out_valid || out_ready, and in_ready is exactly advance; when advance is
// low every stage holds, so out_valid/out_data stay stable under stall and
// bubbles are only removed by normal advance.
module fixed_to_float_packer
  import cordic_pkg::*;
#(
  parameter int FRAC_BITS = FRAC_BITS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  // 127 + 31 - FRAC_BITS; the per-sample lzc is subtracted at 9 bits.
  localparam logic [8:0] EXP_BASE = 9'(FP_BIAS + 31 - FRAC_BITS);

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // ---------------- S1: sign / magnitude ----------------
  logic        s1_valid;
  logic        s1_sign;
  logic [31:0] s1_mag;
  logic [31:0] mag_next;

  // Two's-complement negate; 0x80000000 maps to itself, which read as
  // unsigned is the correct magnitude 2^31.
  assign mag_next = in_data[31] ? (~in_data + 32'd1) : in_data;

  // ---------------- S2: lzc / normalise ----------------
  logic        s2_valid;
  logic        s2_sign;
  logic        s2_zero;
  logic [5:0]  s2_lzc;
  logic [31:0] s2_norm;
  logic [5:0]  lzc_count;
  logic        lzc_zero;

  lzc32 u_lzc (
    .value (s1_mag),
    .count (lzc_count),
    .zero  (lzc_zero)
  );

  // ---------------- S3: exponent / round / pack ----------------
  logic [8:0]  exp_raw;
  logic [8:0]  exp_final;
  logic [22:0] man_trunc;
  logic        guard_bit;
  logic        sticky_bit;
  logic        round_up;
  logic [23:0] man_inc;
  float32_t    packed_result;
  logic        unused_bits;

  assign exp_raw    = EXP_BASE - {3'd0, s2_lzc};
  assign man_trunc  = s2_norm[30:8];
  assign guard_bit  = s2_norm[7];
  assign sticky_bit = |s2_norm[6:0];
  assign round_up   = guard_bit && (sticky_bit || man_trunc[0]);
  assign man_inc    = {1'b0, man_trunc} + {23'd0, round_up};
  // A carry out leaves man_inc[22:0] at zero, so only the exponent moves.
  assign exp_final  = exp_raw + {8'd0, man_inc[23]};

  always_comb begin
    packed_result      = '0;
    packed_result.sign = s2_sign;
    packed_result.exp  = exp_final[7:0];
    packed_result.man  = man_inc[22:0];
    // Zero never produces -0.0.
    if (s2_zero) begin
      packed_result = '0;
    end
  end

  // The hidden bit and exponent bit 8 are never needed: the exponent range
  // for legal FRAC_BITS is 96..159.
  assign unused_bits = ^{exp_final[8], s2_norm[31]};

  // ---------------- control and output registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 32'd0;
    end else if (advance) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_data <= packed_result;
      end
    end
  end

  // Stage data; qualified by the valid bits, so no reset needed.
  always_ff @(posedge clk) begin
    if (advance) begin
      s1_sign <= in_data[31];
      s1_mag  <= mag_next;
      s2_sign <= s1_sign;
      s2_zero <= lzc_zero;
      s2_lzc  <= lzc_count;
      s2_norm <= s1_mag << lzc_count;
    end
  end

endmodule
